// File: rtl/fpshift_arbiter.sv
// fpshift_arbiter: shares one 24-bit barrel shifter between two requesters.
// Round-robin grant, one registered response stage with sticky bit and requester ID.
//
// Handshake: a request transfers on reqN_valid && reqN_ready, and a response
// transfers on rsp_valid && rsp_ready. reqN_ready is driven combinationally from
// rsp_ready and both valids. At most one ready is high in a cycle. A requester may
// change its request while not ready.
module fpshift_arbiter #(
    parameter int W  = 24,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_dir,
    input  logic [MW-1:0] req0_mag,
    input  logic [W-1:0]  req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_dir,
    input  logic [MW-1:0] req1_mag,
    input  logic [W-1:0]  req1_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_sticky
);

    // Round-robin pointer. It holds the requester that was served most recently.
    logic          last;
    logic          accept;
    logic          grant0;
    logic          grant1;
    logic          xfer;
    logic          sel_id;
    logic          sel_dir;
    logic [MW-1:0] sel_mag;
    logic [W-1:0]  sel_data;

    // Shifter stages, one per magnitude bit.
    logic [W-1:0]  s0, s1, s2, s3, s4, s5;
    logic [W-1:0]  shifted;
    logic [W-1:0]  mask;
    logic          overflow;
    logic          sticky;

    // Arbitration: on a tie, grant the requester not served last. Readies are gated by accept and reset.
    always_comb begin
        accept     = !rsp_valid || rsp_ready;
        grant0     = req0_valid && (!req1_valid || last);
        grant1     = req1_valid && (!req0_valid || !last);
        req0_ready = !rst && accept && grant0;
        req1_ready = !rst && accept && grant1;
        xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_id     = grant1;
        sel_dir    = grant1 ? req1_dir  : req0_dir;
        sel_mag    = grant1 ? req1_mag  : req0_mag;
        sel_data   = grant1 ? req1_data : req0_data;
    end

    // Logarithmic shifter on mag[4:0]. Upper magnitude bits force zero.
    // The sticky bit comes from a mask of the low bits that the right shift discards.
    always_comb begin
        s0       = sel_data;
        s1       = sel_mag[0] ? (sel_dir ? (s0 << 1)  : (s0 >> 1))  : s0;
        s2       = sel_mag[1] ? (sel_dir ? (s1 << 2)  : (s1 >> 2))  : s1;
        s3       = sel_mag[2] ? (sel_dir ? (s2 << 4)  : (s2 >> 4))  : s2;
        s4       = sel_mag[3] ? (sel_dir ? (s3 << 8)  : (s3 >> 8))  : s3;
        s5       = sel_mag[4] ? (sel_dir ? (s4 << 16) : (s4 >> 16)) : s4;
        overflow = |sel_mag[MW-1:5];
        shifted  = overflow ? '0 : s5;
        if (overflow || (32'(sel_mag[4:0]) >= W)) begin
            mask = '1;
        end else begin
            mask = (W'(1) << sel_mag[4:0]) - W'(1);
        end
        sticky = !sel_dir && (|(sel_data & mask));
    end

    // Response register. It loads on a request transfer, empties when accept holds
    // without a transfer, and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_sticky <= 1'b0;
            rsp_id     <= 1'b0;
            last       <= 1'b1;
        end else if (accept) begin
            rsp_valid <= xfer;
            if (xfer) begin
                rsp_data   <= shifted;
                rsp_sticky <= sticky;
                rsp_id     <= sel_id;
                last       <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_fpshift_arbiter.sv
// tb_fpshift_arbiter: scenario tasks that compare the DUT against a behavioural
// model of the arbiter and shifter, with a queue of expected responses.
module tb_fpshift_arbiter;
    localparam int W  = 24;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic          req0_dir = 1'b0;
    logic [MW-1:0] req0_mag = '0;
    logic [W-1:0]  req0_data = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic          req1_dir = 1'b0;
    logic [MW-1:0] req1_mag = '0;
    logic [W-1:0]  req1_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_sticky;

    int checks = 0;
    int errors = 0;

    // Expected responses, packed as {id, sticky, data}.
    logic [W+1:0] exp_q[$];
    // Model state: whether a response is pending, and which requester was served last.
    logic m_valid = 1'b0;
    logic m_last  = 1'b1;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    fpshift_arbiter #(.W(W), .MW(MW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir),
        .req0_mag(req0_mag), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir),
        .req1_mag(req1_mag), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_sticky(rsp_sticky)
    );

    // Reference shift computed with wide integer arithmetic. Returns {sticky, data}.
    function automatic logic [W:0] ref_shift(input logic dir, input logic [MW-1:0] mag,
                                             input logic [W-1:0] data);
        logic [63:0] d;
        logic [W-1:0] r;
        logic s;
        d = 64'(data);
        if (int'(mag) >= W) begin
            r = '0;
            s = !dir && (data != '0);
        end else if (dir) begin
            r = W'(d << mag);
            s = 1'b0;
        end else begin
            r = W'(d >> mag);
            s = ((d & ((64'd1 << mag) - 64'd1)) != 64'd0);
        end
        return {s, r};
    endfunction

    function automatic logic [MW-1:0] rand_mag();
        if ($urandom_range(0, 7) == 0) return MW'($urandom_range(0, 255));
        return MW'($urandom_range(0, 26));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b1;
        exp_q.delete();
    endtask

    // One clock cycle. The inputs are already driven. The task checks outputs at
    // the falling edge, advances the model, and returns #1 after the rising edge.
    task automatic do_cycle();
        logic acc, g0, g1, xfer, gid;
        logic [W:0] res;
        @(negedge clk);
        acc = !m_valid || rsp_ready;
        g0  = req0_valid && (!req1_valid || m_last);
        g1  = req1_valid && (!req0_valid || !m_last);
        checks++;
        if (req0_ready !== (acc && g0)) begin
            errors++;
            $display("FAIL req0_ready: got %b expected %b", req0_ready, acc && g0);
        end
        checks++;
        if (req1_ready !== (acc && g1)) begin
            errors++;
            $display("FAIL req1_ready: got %b expected %b", req1_ready, acc && g1);
        end
        checks++;
        if (rsp_valid !== m_valid) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_valid);
        end
        if (m_valid && exp_q.size() > 0) begin
            checks++;
            if ({rsp_id, rsp_sticky, rsp_data} !== exp_q[0]) begin
                errors++;
                $display("FAIL rsp_payload: got id=%b sticky=%b data=%h expected id=%b sticky=%b data=%h",
                         rsp_id, rsp_sticky, rsp_data, exp_q[0][W+1], exp_q[0][W], exp_q[0][W-1:0]);
            end
        end
        if (m_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        xfer = acc && (g0 || g1);
        if (xfer) begin
            gid = g1;
            res = g1 ? ref_shift(req1_dir, req1_mag, req1_data)
                     : ref_shift(req0_dir, req0_mag, req0_data);
            exp_q.push_back({gid, res});
            m_last = gid;
        end
        if (acc) m_valid = xfer;
        @(posedge clk);
        #1;
    endtask

    // Sends one request from requester id, checks the registered result against constants, then drains it.
    task automatic run_single(input logic id, input logic dir, input logic [MW-1:0] mag,
                              input logic [W-1:0] data, input logic [W-1:0] ed,
                              input logic es, input string name);
        rsp_ready  = 1'b1;
        req0_valid = (id == 1'b0);
        req1_valid = (id == 1'b1);
        if (id) begin
            req1_dir = dir; req1_mag = mag; req1_data = data;
        end else begin
            req0_dir = dir; req0_mag = mag; req0_data = data;
        end
        do_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== ed || rsp_sticky !== es) begin
            errors++;
            $display("FAIL %s: got v=%b id=%b data=%h sticky=%b expected v=1 id=%b data=%h sticky=%b",
                     name, rsp_valid, rsp_id, rsp_data, rsp_sticky, id, ed, es);
        end
        do_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_sticky !== 1'b0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b data=%h sticky=%b id=%b expected all zero",
                     rsp_valid, rsp_data, rsp_sticky, rsp_id);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_right_shift();
        run_single(1'b0, 1'b0, 8'd4,  24'h800001, 24'h080000, 1'b1, "right_sticky1");
        run_single(1'b0, 1'b0, 8'd4,  24'h800010, 24'h080001, 1'b0, "right_sticky0");
        run_single(1'b1, 1'b0, 8'd0,  24'hABCDEF, 24'hABCDEF, 1'b0, "right_mag0");
        run_single(1'b1, 1'b0, 8'd23, 24'hFFFFFF, 24'h000001, 1'b1, "right_mag23");
    endtask

    task automatic test_overflow();
        run_single(1'b1, 1'b0, 8'h20, 24'h000001, 24'h000000, 1'b1, "ovf_mag20");
        run_single(1'b1, 1'b0, 8'd24, 24'h000000, 24'h000000, 1'b0, "ovf_mag24_zero");
        run_single(1'b0, 1'b1, 8'hFF, 24'hFFFFFF, 24'h000000, 1'b0, "ovf_left_ff");
        run_single(1'b0, 1'b0, 8'd31, 24'h400000, 24'h000000, 1'b1, "ovf_right_31");
    endtask

    task automatic test_left_shift();
        run_single(1'b0, 1'b1, 8'd1,  24'h800001, 24'h000002, 1'b0, "left_msb_lost");
        run_single(1'b0, 1'b1, 8'd0,  24'h123456, 24'h123456, 1'b0, "left_mag0");
        run_single(1'b1, 1'b1, 8'd23, 24'h000003, 24'h800000, 1'b0, "left_mag23");
    endtask

    task automatic test_fairness();
        test_reset();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_dir = 1'($urandom); req0_mag = rand_mag(); req0_data = W'($urandom);
            req1_dir = 1'($urandom); req1_mag = rand_mag(); req1_data = W'($urandom);
            do_cycle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)) begin
                errors++;
                $display("FAIL fairness[%0d]: got v=%b id=%b expected v=1 id=%0d", i, rsp_valid, rsp_id, i % 2);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_cycle();
    endtask

    task automatic test_backpressure();
        logic [W+1:0] held;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        do_cycle();
        held = {rsp_id, rsp_sticky, rsp_data};
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_mag = rand_mag(); req0_data = W'($urandom);
            req1_mag = rand_mag(); req1_data = W'($urandom);
            do_cycle();
            checks++;
            if ({rsp_id, rsp_sticky, rsp_data} !== held || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got %h v=%b expected %h v=1",
                         i, {rsp_id, rsp_sticky, rsp_data}, rsp_valid, held);
            end
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_mag = rand_mag(); req0_data = W'($urandom);
            req1_mag = rand_mag(); req1_data = W'($urandom);
            do_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_cycle();
    endtask

    task automatic test_reset_midstream();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        do_cycle();
        do_cycle();
        rsp_ready = 1'b0;
        do_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b data=%h expected v=0 data=000000", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        do_cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first_tie: got v=%b id=%b expected v=1 id=0", rsp_valid, rsp_id);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_dir = 1'($urandom); req0_mag = rand_mag(); req0_data = W'($urandom);
            req1_dir = 1'($urandom); req1_mag = rand_mag(); req1_data = W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            do_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        do_cycle();
        do_cycle();
        checks++;
        if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending v=%b expected 0 pending v=0", exp_q.size(), rsp_valid);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_right_shift();
        test_overflow();
        test_left_shift();
        test_fairness();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
